// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Purpose:
//   Round-robin, burst-based arbiter that shares the single write port of the
//   asynchronous FIFO among NUM_REQ requesters. Lives entirely in the write
//   clock domain. A winner owns the port until it sends its last beat, reaches
//   MAX_BURST beats, or leaves req_valid low for STALL_LIMIT granted cycles.
//   No write is ever issued while the FIFO reports full.
//
// Ports:
//   i_writeClock   write-domain clock, all state updates on its rising edge
//   i_writeReset   asynchronous active-high reset
//   i_reqValid     per-requester data valid               [NUM_REQ]
//   i_reqLast      per-requester last beat of a packet    [NUM_REQ]
//   i_reqData      packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_reqReady     one-hot (or zero) accept strobe        [NUM_REQ]
//   i_writeFull    FIFO full flag (write domain)
//   o_writeEnable  FIFO write strobe
//   o_writeData    FIFO write data                        [DATA_WIDTH]
//   o_grantValid   high while a burst is in progress
//   o_grantId      index of the current or last owner     [GRANT_WIDTH]
//   o_beatCount    beats transferred in the current burst [clog2(MAX_BURST)+1]
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int GRANT_WIDTH = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 8,
    parameter int STALL_LIMIT = 15
) (
    input  logic                          i_writeClock,
    input  logic                          i_writeReset,
    input  logic [NUM_REQ-1:0]            i_reqValid,
    input  logic [NUM_REQ-1:0]            i_reqLast,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_reqData,
    output logic [NUM_REQ-1:0]            o_reqReady,
    input  logic                          i_writeFull,
    output logic                          o_writeEnable,
    output logic [DATA_WIDTH-1:0]         o_writeData,
    output logic                          o_grantValid,
    output logic [GRANT_WIDTH-1:0]        o_grantId,
    output logic [$clog2(MAX_BURST):0]    o_beatCount
);

    localparam int BEAT_WIDTH  = $clog2(MAX_BURST) + 1;
    localparam int STALL_WIDTH = $clog2(STALL_LIMIT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [GRANT_WIDTH-1:0]   r_grantId;
    logic [GRANT_WIDTH-1:0]   w_grantIdNext;
    logic [GRANT_WIDTH-1:0]   r_lastGrant;
    logic [GRANT_WIDTH-1:0]   w_lastGrantNext;
    logic [BEAT_WIDTH-1:0]    r_beatCount;
    logic [BEAT_WIDTH-1:0]    w_beatCountNext;
    logic [STALL_WIDTH-1:0]   r_stallCnt;
    logic [STALL_WIDTH-1:0]   w_stallCntNext;

    logic                     w_inBurst;
    logic                     w_anyValid;
    logic [GRANT_WIDTH-1:0]   w_winner;
    logic                     w_selValid;
    logic                     w_selLast;
    logic [DATA_WIDTH-1:0]    w_selData;
    logic                     w_transfer;
    logic                     w_burstEnd;
    logic                     w_stallExpired;

    assign w_inBurst  = (r_state == BURST);
    assign w_anyValid = |i_reqValid;

    // Round-robin search: start just above the previous owner and wrap, so the
    // requester that released most recently is considered last. Only the first
    // hit in search order is kept.
    always_comb begin : winnerSearch
        int  searchIdx;
        logic found;
        w_winner  = '0;
        found     = 1'b0;
        searchIdx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            searchIdx = (int'(r_lastGrant) + k) % NUM_REQ;
            if (!found && i_reqValid[searchIdx]) begin
                found    = 1'b1;
                w_winner = GRANT_WIDTH'(searchIdx);
            end
        end
    end

    // Select the current owner's valid, last and data lanes. An explicit
    // compare-and-pick loop keeps the mux well defined even when NUM_REQ is
    // not a power of two.
    always_comb begin : ownerMux
        w_selValid = 1'b0;
        w_selLast  = 1'b0;
        w_selData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grantId == GRANT_WIDTH'(i)) begin
                w_selValid = i_reqValid[i];
                w_selLast  = i_reqLast[i];
                w_selData  = i_reqData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A beat moves only while granted, the owner is valid and the FIFO has
    // room. Gating on the full flag here is what guarantees a full FIFO is
    // never written.
    assign w_transfer     = w_inBurst & w_selValid & ~i_writeFull;
    assign w_burstEnd     = w_transfer &
                            (w_selLast | (r_beatCount == BEAT_WIDTH'(MAX_BURST - 1)));
    assign w_stallExpired = w_inBurst & ~w_selValid &
                            (r_stallCnt == STALL_WIDTH'(STALL_LIMIT - 1));

    // Accept strobe goes only to the owner and only when the FIFO has room.
    // It is combinational from registered state so it drops the same instant
    // reset is asserted.
    always_comb begin : readyDecode
        o_reqReady = '0;
        if (w_inBurst && !i_writeFull) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_grantId == GRANT_WIDTH'(i)) begin
                    o_reqReady[i] = 1'b1;
                end
            end
        end
    end

    // FIFO-side outputs. Data is forced to zero outside a burst so the FIFO
    // port never shows a stale requester lane.
    assign o_writeEnable = w_transfer;
    assign o_writeData   = w_inBurst ? w_selData : '0;
    assign o_grantValid  = w_inBurst;
    assign o_grantId     = r_grantId;
    assign o_beatCount   = r_beatCount;

    // Next-state logic. IDLE registers the winner and opens a burst one cycle
    // later. BURST counts beats, closes on a last beat or the burst cap, and
    // revokes a requester that stays silent for too long. Backpressure from a
    // full FIFO with the owner still valid is not a requester stall, so the
    // stall counter clears whenever the owner is valid.
    always_comb begin : nextStateLogic
        w_stateNext     = r_state;
        w_grantIdNext   = r_grantId;
        w_lastGrantNext = r_lastGrant;
        w_beatCountNext = r_beatCount;
        w_stallCntNext  = r_stallCnt;

        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_stateNext     = BURST;
                    w_grantIdNext   = w_winner;
                    w_beatCountNext = '0;
                    w_stallCntNext  = '0;
                end
            end

            BURST: begin
                if (w_selValid) begin
                    w_stallCntNext = '0;
                end else begin
                    w_stallCntNext = r_stallCnt + STALL_WIDTH'(1);
                end

                if (w_burstEnd) begin
                    w_stateNext     = IDLE;
                    w_lastGrantNext = r_grantId;
                    w_beatCountNext = '0;
                end else if (w_transfer) begin
                    w_beatCountNext = r_beatCount + BEAT_WIDTH'(1);
                end else if (w_stallExpired) begin
                    w_stateNext     = IDLE;
                    w_lastGrantNext = r_grantId;
                    w_beatCountNext = '0;
                    w_stallCntNext  = '0;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // State register. The last-grant pointer resets to the top index so the
    // first search after reset begins at requester 0.
    always_ff @(posedge i_writeClock or posedge i_writeReset) begin
        if (i_writeReset) begin
            r_state     <= IDLE;
            r_grantId   <= '0;
            r_lastGrant <= GRANT_WIDTH'(NUM_REQ - 1);
            r_beatCount <= '0;
            r_stallCnt  <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_grantId   <= w_grantIdNext;
            r_lastGrant <= w_lastGrantNext;
            r_beatCount <= w_beatCountNext;
            r_stallCnt  <= w_stallCntNext;
        end
    end

endmodule
